// File: rtl/editor_rtc_pkg.sv
// editor_rtc_pkg: shared types and helpers for the RTC field editor.
//   - estado_t   : editor state (IDLE / EDIT / CONFIRM)
//   - tipo_t     : kind of BCD field (hour, minute, second, day, month, year)
//   - default PS/2 make codes for the navigation/edit keys
//   - MODO encodings and per-field-type limits
//   - dias_mes() : days in a month, leap-year aware (20yy, yy mod 4 == 0)
package editor_rtc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT    = 2'd1,
    CONFIRM = 2'd2
  } estado_t;

  typedef enum logic [2:0] {
    T_HH  = 3'd0,
    T_MIN = 3'd1,
    T_SEG = 3'd2,
    T_DD  = 3'd3,
    T_MES = 3'd4,
    T_YY  = 3'd5
  } tipo_t;

  localparam logic [7:0] K_ARRIBA_DEF = 8'h75;
  localparam logic [7:0] K_ABAJO_DEF  = 8'h72;
  localparam logic [7:0] K_IZQ_DEF    = 8'h6B;
  localparam logic [7:0] K_DER_DEF    = 8'h74;
  localparam logic [7:0] K_ENTER_DEF  = 8'h5A;

  localparam int MODO_HORA     = 0;
  localparam int MODO_FECHA    = 1;
  localparam int MODO_COMPLETO = 2;

  localparam logic [7:0] HH_MAX  = 8'h23;
  localparam logic [7:0] MS_MAX  = 8'h59;
  localparam logic [7:0] DD_MAX  = 8'h31;
  localparam logic [7:0] MES_MAX = 8'h12;
  localparam logic [7:0] YY_MAX  = 8'h99;

  // Field order: date-only mode is dd,mm,yy; otherwise hh,mm,ss[,dd,mm,yy].
  function automatic tipo_t tipo_campo(input int modo, input int i);
    if (modo == MODO_FECHA) begin
      case (i)
        0:       return T_DD;
        1:       return T_MES;
        default: return T_YY;
      endcase
    end
    case (i)
      0:       return T_HH;
      1:       return T_MIN;
      2:       return T_SEG;
      3:       return T_DD;
      4:       return T_MES;
      default: return T_YY;
    endcase
  endfunction

  function automatic logic [7:0] min_campo(input tipo_t t);
    return (t == T_DD || t == T_MES) ? 8'h01 : 8'h00;
  endfunction

  // Static upper bound; the day field is further limited by dias_mes().
  function automatic logic [7:0] max_campo(input tipo_t t);
    case (t)
      T_HH:    return HH_MAX;
      T_MIN:   return MS_MAX;
      T_SEG:   return MS_MAX;
      T_DD:    return DD_MAX;
      T_MES:   return MES_MAX;
      default: return YY_MAX;
    endcase
  endfunction

  function automatic logic campo_valido(input logic [7:0] v, input tipo_t t);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
           (v >= min_campo(t)) && (v <= max_campo(t));
  endfunction

  // Reset image for up to six fields; callers keep the low 8*N bits.
  function automatic logic [47:0] reset_campos(input int modo);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[8*i +: 8] = min_campo(tipo_campo(modo, i));
    return r;
  endfunction

  // yy is decimal BCD: 10a+b is a multiple of 4 when b is 0/4/8 with a even,
  // or 2/6 with a odd, so only the tens LSB and the units nibble matter.
  function automatic logic [7:0] dias_mes(input logic [7:0] mes, input logic [7:0] yy);
    logic bis;
    if (yy[4]) bis = (yy[3:0] == 4'h2) || (yy[3:0] == 4'h6);
    else       bis = (yy[3:0] == 4'h0) || (yy[3:0] == 4'h4) || (yy[3:0] == 4'h8);
    case (mes)
      8'h02:                      return bis ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/bcd_paso.sv
// bcd_paso: combinational +/-1 step of one two-digit BCD field with wrap.
//   valor_i : current BCD value (assumed valid BCD within [min_i, max_i])
//   min_i   : lowest legal value
//   max_i   : highest legal value
//   subir_i : 1 = increment, 0 = decrement
//   sig_o   : stepped value; max wraps to min on increment, min to max on decrement
module bcd_paso (
  input  logic [7:0] valor_i,
  input  logic [7:0] min_i,
  input  logic [7:0] max_i,
  input  logic       subir_i,
  output logic [7:0] sig_o
);

  // >= / <= rather than == so a value sitting above a shrunken day limit
  // still wraps instead of counting past it.
  always_comb begin
    sig_o = valor_i;
    if (subir_i) begin
      if (valor_i >= max_i)              sig_o = min_i;
      else if (valor_i[3:0] == 4'h9)     sig_o = {valor_i[7:4] + 4'h1, 4'h0};
      else                               sig_o = valor_i + 8'h01;
    end else begin
      if (valor_i <= min_i)              sig_o = max_i;
      else if (valor_i[3:0] == 4'h0)     sig_o = {valor_i[7:4] - 4'h1, 4'h9};
      else                               sig_o = valor_i - 8'h01;
    end
  end

endmodule

// File: rtl/editor_campos_rtc.sv
// editor_campos_rtc: keyboard-driven editor for N packed BCD time/date fields.
// Optional build macro: EDITOR_CARGA_EN adds a parallel load (carga/dato_in).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en_edit         : edit-mode level from the keyboard block
//   key_code        : last PS/2 make code, valid while got_code_tick is high
//   got_code_tick   : one-cycle key strobe
//   I_ack           : PicoBlaze acknowledge that clears listo
//   carga, dato_in  : (EDITOR_CARGA_EN only) load all fields while idle
//   posicion        : selected field index
//   dato_bus        : packed BCD fields, field i at [8*i +: 8]
//   listo           : commit pending (interrupt request)
//   editando        : high while editing
module editor_campos_rtc
  import editor_rtc_pkg::*;
#(
  parameter int         MODO     = 0,
  parameter int         N_CAMPOS = 3,
  parameter logic [7:0] K_ARRIBA = K_ARRIBA_DEF,
  parameter logic [7:0] K_ABAJO  = K_ABAJO_DEF,
  parameter logic [7:0] K_IZQ    = K_IZQ_DEF,
  parameter logic [7:0] K_DER    = K_DER_DEF,
  parameter logic [7:0] K_ENTER  = K_ENTER_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_edit,
  input  logic [7:0]                  key_code,
  input  logic                        got_code_tick,
  input  logic                        I_ack,
`ifdef EDITOR_CARGA_EN
  input  logic                        carga,
  input  logic [8*N_CAMPOS-1:0]       dato_in,
`endif
  output logic [$clog2(N_CAMPOS)-1:0] posicion,
  output logic [8*N_CAMPOS-1:0]       dato_bus,
  output logic                        listo,
  output logic                        editando
);

  localparam int PW = $clog2(N_CAMPOS);
  localparam logic [PW-1:0] POS_MAX = PW'(N_CAMPOS - 1);
  localparam bit TIENE_FECHA = (MODO != MODO_HORA);
  // Date field indices; unused (but kept in range) in time-only mode.
  localparam int I_DD  = (MODO == MODO_COMPLETO) ? 3 : 0;
  localparam int I_MES = (MODO == MODO_COMPLETO) ? 4 : 1;
  localparam int I_YY  = (MODO == MODO_COMPLETO) ? 5 : 2;
  localparam logic [47:0] RST_TODO = reset_campos(MODO);
  localparam logic [8*N_CAMPOS-1:0] CAMPOS_RST = RST_TODO[8*N_CAMPOS-1:0];

  generate
    if (!(((MODO == MODO_HORA || MODO == MODO_FECHA) && N_CAMPOS == 3) ||
          (MODO == MODO_COMPLETO && N_CAMPOS == 6))) begin : g_cfg_error
      $error("editor_campos_rtc: MODO/N_CAMPOS combination not supported");
    end
  endgenerate

  estado_t                      estado_q;
  logic [PW-1:0]                posicion_q;
  logic                         listo_q;
  logic                         editando_q;
  logic [N_CAMPOS-1:0][7:0]     campos_q;
  logic [N_CAMPOS-1:0][7:0]     campos_d;
  logic [N_CAMPOS-1:0][7:0]     paso_v;
  logic [7:0]                   dmax_act;
  logic [7:0]                   dmax_d;
  logic                         subir;
  logic                         edita_valor;

  assign subir       = (key_code == K_ARRIBA);
  assign edita_valor = (estado_q == EDIT) && en_edit && got_code_tick &&
                       ((key_code == K_ARRIBA) || (key_code == K_ABAJO));
  assign dmax_act    = TIENE_FECHA ? dias_mes(campos_q[I_MES], campos_q[I_YY]) : DD_MAX;

`ifdef EDITOR_CARGA_EN
  logic [N_CAMPOS-1:0][7:0] carga_v;
`endif

  for (genvar i = 0; i < N_CAMPOS; i++) begin : g_campo
    localparam tipo_t T = tipo_campo(MODO, i);
    logic [7:0] vmax;
    assign vmax = (T == T_DD) ? dmax_act : max_campo(T);

    bcd_paso u_paso (
      .valor_i (campos_q[i]),
      .min_i   (min_campo(T)),
      .max_i   (vmax),
      .subir_i (subir),
      .sig_o   (paso_v[i])
    );

`ifdef EDITOR_CARGA_EN
    assign carga_v[i] = campo_valido(dato_in[8*i +: 8], T) ? dato_in[8*i +: 8] : min_campo(T);
`endif
  end

  // Field next-state: load, step, then clamp the day to the (possibly new)
  // month length so a month/year edit and its clamp land on the same edge.
  always_comb begin
    campos_d = campos_q;
    dmax_d   = DD_MAX;
`ifdef EDITOR_CARGA_EN
    if (estado_q == IDLE && carga) campos_d = carga_v;
`endif
    if (edita_valor) campos_d[posicion_q] = paso_v[posicion_q];
    if (TIENE_FECHA) begin
      dmax_d = dias_mes(campos_d[I_MES], campos_d[I_YY]);
      if (campos_d[I_DD] > dmax_d) campos_d[I_DD] = dmax_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= IDLE;
      posicion_q <= '0;
      listo_q    <= 1'b0;
      editando_q <= 1'b0;
      campos_q   <= CAMPOS_RST;
    end else begin
      campos_q <= campos_d;
      case (estado_q)
        IDLE: begin
          if (en_edit) begin
            estado_q   <= EDIT;
            editando_q <= 1'b1;
          end
        end
        EDIT: begin
          // Leaving edit mode beats any key arriving in the same cycle.
          if (!en_edit) begin
            estado_q   <= IDLE;
            editando_q <= 1'b0;
          end else if (got_code_tick) begin
            if (key_code == K_DER) begin
              posicion_q <= (posicion_q == POS_MAX) ? '0 : posicion_q + PW'(1);
            end else if (key_code == K_IZQ) begin
              posicion_q <= (posicion_q == '0) ? POS_MAX : posicion_q - PW'(1);
            end else if (key_code == K_ENTER) begin
              estado_q   <= CONFIRM;
              listo_q    <= 1'b1;
              editando_q <= 1'b0;
            end
          end
        end
        CONFIRM: begin
          if (I_ack) begin
            estado_q <= IDLE;
            listo_q  <= 1'b0;
          end
        end
        default: begin
          estado_q   <= IDLE;
          listo_q    <= 1'b0;
          editando_q <= 1'b0;
        end
      endcase
    end
  end

  assign posicion = posicion_q;
  assign dato_bus = campos_q;
  assign listo    = listo_q;
  assign editando = editando_q;

endmodule

// File: tb/tb_editor_campos_rtc.sv
// tb_editor_campos_rtc: directed bench for editor_campos_rtc.
// u0 = time mode (hh,mm,ss), u1 = date mode (dd,mm,yy); with EDITOR_CARGA_EN
// a full-mode instance u2 also exercises the parallel load.
module tb_editor_campos_rtc;

  localparam logic [7:0] UP  = 8'h75;
  localparam logic [7:0] DN  = 8'h72;
  localparam logic [7:0] IZQ = 8'h6B;
  localparam logic [7:0] DER = 8'h74;
  localparam logic [7:0] ENT = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       en   [3];
  logic       tick [3];
  logic       ack  [3];
  logic [7:0] kc   [3];
  logic        carga_off;
  logic [23:0] din_off;
  logic        carga2;
  logic [47:0] din2;

  logic [1:0]  pos0, pos1;
  logic [2:0]  pos2;
  logic [23:0] bus0, bus1;
  logic [47:0] bus2;
  logic        l0, l1, l2, e0, e1, e2;

  always #5 clk = ~clk;

  editor_campos_rtc #(.MODO(0), .N_CAMPOS(3)) u0 (
    .clk(clk), .rst(rst), .en_edit(en[0]), .key_code(kc[0]),
    .got_code_tick(tick[0]), .I_ack(ack[0]),
`ifdef EDITOR_CARGA_EN
    .carga(carga_off), .dato_in(din_off),
`endif
    .posicion(pos0), .dato_bus(bus0), .listo(l0), .editando(e0)
  );

  editor_campos_rtc #(.MODO(1), .N_CAMPOS(3)) u1 (
    .clk(clk), .rst(rst), .en_edit(en[1]), .key_code(kc[1]),
    .got_code_tick(tick[1]), .I_ack(ack[1]),
`ifdef EDITOR_CARGA_EN
    .carga(carga_off), .dato_in(din_off),
`endif
    .posicion(pos1), .dato_bus(bus1), .listo(l1), .editando(e1)
  );

`ifdef EDITOR_CARGA_EN
  editor_campos_rtc #(.MODO(2), .N_CAMPOS(6)) u2 (
    .clk(clk), .rst(rst), .en_edit(en[2]), .key_code(kc[2]),
    .got_code_tick(tick[2]), .I_ack(ack[2]),
    .carga(carga2), .dato_in(din2),
    .posicion(pos2), .dato_bus(bus2), .listo(l2), .editando(e2)
  );
`else
  assign pos2 = '0;
  assign bus2 = '0;
  assign l2   = 1'b0;
  assign e2   = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          d;
    logic [47:0] bus;
    logic [2:0]  pos;
    logic        listo;
    logic        edit;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic revisar();
    exp_t e;
    logic [47:0] ob;
    logic [2:0]  op;
    logic        ol, oe;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    case (e.d)
      0:       begin ob = {24'h0, bus0}; op = {1'b0, pos0}; ol = l0; oe = e0; end
      1:       begin ob = {24'h0, bus1}; op = {1'b0, pos1}; ol = l1; oe = e1; end
      default: begin ob = bus2;          op = pos2;         ol = l2; oe = e2; end
    endcase
    chk({e.tag, "_bus"},      ob,          e.bus);
    chk({e.tag, "_pos"},      {45'h0, op}, {45'h0, e.pos});
    chk({e.tag, "_listo"},    {47'h0, ol}, {47'h0, e.listo});
    chk({e.tag, "_editando"}, {47'h0, oe}, {47'h0, e.edit});
  endtask

  // Called at a falling edge with inputs already set; one rising edge later
  // the outputs are compared against the pushed expectation.
  task automatic paso(input int d, input string tag, input logic [47:0] eb,
                      input logic [2:0] ep, input logic el, input logic ee);
    exp_t e;
    e.tag = tag; e.d = d; e.bus = eb; e.pos = ep; e.listo = el; e.edit = ee;
    sb.push_back(e);
    @(negedge clk);
    tick[d] = 1'b0;
    ack[d]  = 1'b0;
    revisar();
  endtask

  task automatic tecla(input int d, input logic [7:0] k, input string tag,
                       input logic [47:0] eb, input logic [2:0] ep,
                       input logic el, input logic ee);
    kc[d]   = k;
    tick[d] = 1'b1;
    paso(d, tag, eb, ep, el, ee);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; tick[i] = 1'b0; ack[i] = 1'b0; kc[i] = 8'h00;
    end
    carga_off = 1'b0; din_off = '0; carga2 = 1'b0; din2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    paso(0, "rst_t", 48'h0, 0, 0, 0);
    paso(1, "rst_f", 48'h000101, 0, 0, 0);
    tecla(0, UP, "idle_key", 48'h0, 0, 0, 0);

    // Time mode: wrap, BCD carry, cursor, commit handshake
    en[0] = 1'b1;
    paso(0, "t_enter_edit", 48'h0, 0, 0, 1);
    tecla(0, DN, "hh_down_wrap", 48'h23, 0, 0, 1);
    tecla(0, UP, "hh_up_wrap", 48'h00, 0, 0, 1);
    for (int k = 1; k <= 10; k++) tecla(0, UP, "hh_up", {40'h0, bcd(k)}, 0, 0, 1);
    tecla(0, DER, "t_right1", 48'h10, 1, 0, 1);
    tecla(0, DER, "t_right2", 48'h10, 2, 0, 1);
    tecla(0, DN, "ss_down_wrap", 48'h590010, 2, 0, 1);
    tecla(0, UP, "ss_up_wrap", 48'h000010, 2, 0, 1);
    tecla(0, DER, "t_right_wrap", 48'h10, 0, 0, 1);
    tecla(0, IZQ, "t_left_wrap", 48'h10, 2, 0, 1);
    tecla(0, 8'h1C, "other_key", 48'h10, 2, 0, 1);
    tecla(0, ENT, "t_commit", 48'h10, 2, 1, 0);
    tecla(0, UP, "confirm_key_ign", 48'h10, 2, 1, 0);
    en[0] = 1'b0;
    paso(0, "confirm_en_ign", 48'h10, 2, 1, 0);
    en[0] = 1'b1;
    ack[0] = 1'b1;
    tecla(0, UP, "ack_beats_key", 48'h10, 2, 0, 0);
    paso(0, "t_reenter", 48'h10, 2, 0, 1);
    en[0] = 1'b0;
    tecla(0, UP, "en_drop_prio", 48'h10, 2, 0, 0);
    ack[0] = 1'b1;
    paso(0, "ack_idle_ign", 48'h10, 2, 0, 0);

    // Date mode: month lengths, leap years, day clamp
    en[1] = 1'b1;
    paso(1, "f_enter_edit", 48'h000101, 0, 0, 1);
    tecla(1, DN, "dd_01_to_31", 48'h000131, 0, 0, 1);
    tecla(1, DER, "f_right", 48'h000131, 1, 0, 1);
    tecla(1, UP, "jan_to_feb_y00", 48'h000229, 1, 0, 1);
    tecla(1, UP, "feb_to_mar", 48'h000329, 1, 0, 1);
    tecla(1, IZQ, "f_left", 48'h000329, 0, 0, 1);
    tecla(1, UP, "dd_30", 48'h000330, 0, 0, 1);
    tecla(1, UP, "dd_31", 48'h000331, 0, 0, 1);
    tecla(1, IZQ, "f_left_wrap", 48'h000331, 2, 0, 1);
    for (int k = 1; k <= 24; k++) tecla(1, UP, "yy_up", {24'h0, bcd(k), 16'h0331}, 2, 0, 1);
    tecla(1, DER, "f_right_wrap", 48'h240331, 0, 0, 1);
    tecla(1, DER, "f_to_month", 48'h240331, 1, 0, 1);
    tecla(1, DN, "mar_to_feb_y24", 48'h240229, 1, 0, 1);
    tecla(1, DER, "f_to_year", 48'h240229, 2, 0, 1);
    tecla(1, DN, "yy23_clamp", 48'h230228, 2, 0, 1);
    tecla(1, DER, "f_to_day", 48'h230228, 0, 0, 1);
    tecla(1, UP, "dd_28_wrap_01", 48'h230201, 0, 0, 1);
    tecla(1, DN, "dd_01_wrap_28", 48'h230228, 0, 0, 1);
    tecla(1, DER, "f_to_month2", 48'h230228, 1, 0, 1);
    tecla(1, DN, "feb_to_jan", 48'h230128, 1, 0, 1);
    tecla(1, DN, "jan_to_dec", 48'h231228, 1, 0, 1);
    tecla(1, UP, "dec_to_jan", 48'h230128, 1, 0, 1);
    tecla(1, ENT, "f_commit", 48'h230128, 1, 1, 0);

    // Asynchronous reset in CONFIRM, checked before the next rising edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst_listo", {47'h0, l1}, 48'h0);
    chk("async_rst_bus_f", {24'h0, bus1}, 48'h000101);
    chk("async_rst_pos_f", {46'h0, pos1}, 48'h0);
    chk("async_rst_bus_t", {24'h0, bus0}, 48'h0);
    en[0] = 1'b0;
    en[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

`ifdef EDITOR_CARGA_EN
    // Full mode parallel load: month 13 is out of range and loads 01
    paso(2, "c_rst", 48'h000101000000, 0, 0, 0);
    carga2 = 1'b1;
    din2   = 48'h251315304512;
    paso(2, "c_load", 48'h250115304512, 0, 0, 0);
    carga2 = 1'b0;
    en[2]  = 1'b1;
    paso(2, "c_enter_edit", 48'h250115304512, 0, 0, 1);
    carga2 = 1'b1;
    din2   = 48'h000000000000;
    paso(2, "c_load_in_edit_ign", 48'h250115304512, 0, 0, 1);
    carga2 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
